// File: rtl/puf_response_collector_if.sv
// Handshake and result bundle between the PUF cell array / firmware and the
// response collector.
interface puf_response_collector_if;
    logic         Collect_Go;
    logic         Resp_Valid;
    logic [7:0]   Resp_Data;
    logic         Resp_Ready;
    logic [4:0]   Resp_Sel;
    logic         Collect_Done;
    logic         Data_Valid;
    logic [255:0] data_out;
    logic [8:0]   Unstable_Count;

    modport master (
        output Collect_Go, Resp_Valid, Resp_Data,
        input  Resp_Ready, Resp_Sel, Collect_Done, Data_Valid, data_out, Unstable_Count
    );

    modport slave (
        input  Collect_Go, Resp_Valid, Resp_Data,
        output Resp_Ready, Resp_Sel, Collect_Done, Data_Valid, data_out, Unstable_Count
    );
endinterface

// File: rtl/puf_response_collector.sv
// Reads NUM_READS full 256-bit PUF responses byte by byte and resolves each bit by
// temporal majority vote, counting bits whose reads were not unanimous.
module puf_response_collector #(
    parameter int unsigned NUM_READS = 5
) (
    input logic                     clk,
    input logic                     Reset,
    puf_response_collector_if.slave bus
);
    localparam int unsigned NUM_BYTES = 32;
    localparam int unsigned CW        = $clog2(NUM_READS + 1);

    localparam logic [CW-1:0] Half     = CW'(NUM_READS / 2);
    localparam logic [CW-1:0] Full     = CW'(NUM_READS);
    localparam logic [3:0]    LastPass = 4'(NUM_READS - 1);
    localparam logic [4:0]    LastByte = 5'(NUM_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StResolve, StDone} state_e;

    state_e                 state_q, state_d;
    logic [4:0]             byte_q, byte_d;
    logic [3:0]             pass_q, pass_d;
    logic [255:0][CW-1:0]   cnt_q, cnt_d;
    logic [255:0]           data_q, data_d;
    logic [8:0]             unstable_q, unstable_d;
    logic                   valid_q, valid_d;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            byte_q     <= '0;
            pass_q     <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            unstable_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            pass_q     <= pass_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            unstable_q <= unstable_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        pass_d     = pass_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        unstable_d = unstable_q;
        valid_d    = valid_q;

        case (state_q)
            StIdle: begin
                if (bus.Collect_Go) begin
                    byte_d     = '0;
                    pass_d     = '0;
                    cnt_d      = '0;
                    data_d     = '0;
                    unstable_d = '0;
                    valid_d    = 1'b0;
                    state_d    = StCollect;
                end
            end
            StCollect: begin
                // Resp_Ready is high throughout this state, so Resp_Valid alone is the handshake.
                if (bus.Resp_Valid) begin
                    for (int b = 0; b < 8; b++) begin
                        cnt_d[{byte_q, 3'(b)}] = cnt_q[{byte_q, 3'(b)}] + CW'(bus.Resp_Data[b]);
                    end
                    byte_d = byte_q + 5'd1;
                    if (byte_q == LastByte) begin
                        pass_d = pass_q + 4'd1;
                        if (pass_q == LastPass) begin
                            pass_d  = '0;
                            state_d = StResolve;
                        end
                    end
                end
            end
            StResolve: begin
                for (int b = 0; b < 8; b++) begin
                    data_d[{byte_q, 3'(b)}] = cnt_q[{byte_q, 3'(b)}] > Half;
                    if (cnt_q[{byte_q, 3'(b)}] != '0 && cnt_q[{byte_q, 3'(b)}] < Full) begin
                        unstable_d = unstable_d + 9'd1;
                    end
                end
                byte_d = byte_q + 5'd1;
                if (byte_q == LastByte) begin
                    valid_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.Resp_Ready     = (state_q == StCollect);
    assign bus.Resp_Sel       = (state_q == StCollect) ? byte_q : 5'd0;
    assign bus.Collect_Done   = (state_q == StDone);
    assign bus.Data_Valid     = valid_q;
    assign bus.data_out       = data_q;
    assign bus.Unstable_Count = unstable_q;
endmodule

// File: tb/tb_puf_response_collector.sv
// Directed bench for the PUF response collector: NUM_READS=5 and NUM_READS=1 instances,
// expected results queued at stimulus time and checked when Collect_Done fires.
module tb_puf_response_collector;
    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    puf_response_collector_if bus5();
    puf_response_collector_if bus1();

    puf_response_collector #(.NUM_READS(5)) dut5 (.clk(clk), .Reset(Reset), .bus(bus5.slave));
    puf_response_collector #(.NUM_READS(1)) dut1 (.clk(clk), .Reset(Reset), .bus(bus1.slave));

    typedef struct packed {
        logic [255:0] data;
        logic [8:0]   unst;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] pat_mem [5][32];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model5();
        exp_t e;
        int   n;
        e = '0;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            for (int p = 0; p < 5; p++) n += int'(pat_mem[p][i / 8][i % 8]);
            e.data[i] = (n >= 3);
            if (n != 0 && n != 5) e.unst = e.unst + 9'd1;
        end
        return e;
    endfunction

    task automatic fill(input logic [7:0] v);
        for (int p = 0; p < 5; p++) for (int j = 0; j < 32; j++) pat_mem[p][j] = v;
    endtask

    task automatic collect5(input bit gaps, input bit go_pulses, input int abort_at);
        exp_t e;
        int   hs, cyc, lat;
        sb.push_back(model5());
        @(negedge clk) bus5.Collect_Go = 1'b1;
        @(negedge clk) bus5.Collect_Go = 1'b0;
        chk("go_clr_valid", bus5.Data_Valid, 0);
        chk("go_clr_data", bus5.data_out, 0);
        chk("go_clr_unst", bus5.Unstable_Count, 0);
        hs = 0;
        cyc = 0;
        while (hs < 160 && cyc < 4000) begin
            if (hs == abort_at) begin
                bus5.Resp_Valid = 1'b0;
                #1 Reset = 1'b1;
                #2;
                chk("rst_ready", bus5.Resp_Ready, 0);
                chk("rst_sel", bus5.Resp_Sel, 0);
                chk("rst_done", bus5.Collect_Done, 0);
                chk("rst_valid", bus5.Data_Valid, 0);
                chk("rst_data", bus5.data_out, 0);
                chk("rst_unst", bus5.Unstable_Count, 0);
                Reset = 1'b0;
                void'(sb.pop_back());
                @(negedge clk);
                chk("rst_idle_ready", bus5.Resp_Ready, 0);
                return;
            end
            bus5.Resp_Valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus5.Resp_Data  = pat_mem[hs / 32][hs % 32];
            bus5.Collect_Go = go_pulses && (hs == 50);
            #1;
            chk("resp_sel", bus5.Resp_Sel, hs % 32);
            if (bus5.Resp_Valid && bus5.Resp_Ready) hs++;
            @(negedge clk);
            cyc++;
        end
        bus5.Resp_Valid = 1'b0;
        bus5.Collect_Go = 1'b0;
        chk("handshakes", hs, 160);
        chk("ready_resolve", bus5.Resp_Ready, 0);
        lat = 1;
        while (!bus5.Collect_Done && lat < 100) begin
            bus5.Collect_Go = go_pulses && (lat == 10);
            @(negedge clk);
            lat++;
        end
        bus5.Collect_Go = 1'b0;
        chk("done_latency", lat, 33);
        e = sb.pop_front();
        chk("data_out", bus5.data_out, e.data);
        chk("unstable", bus5.Unstable_Count, e.unst);
        chk("valid_done", bus5.Data_Valid, 1);
        @(negedge clk);
        chk("done_pulse", bus5.Collect_Done, 0);
        chk("valid_hold", bus5.Data_Valid, 1);
        chk("data_hold", bus5.data_out, e.data);
    endtask

    task automatic collect1();
        exp_t e;
        int   hs, cyc, lat;
        e = '0;
        for (int j = 0; j < 32; j++) e.data[8*j +: 8] = 8'(j);
        sb.push_back(e);
        @(negedge clk) bus1.Collect_Go = 1'b1;
        @(negedge clk) bus1.Collect_Go = 1'b0;
        hs = 0;
        cyc = 0;
        while (hs < 32 && cyc < 1000) begin
            bus1.Resp_Valid = 1'b1;
            bus1.Resp_Data  = 8'(hs);
            #1;
            chk("n1_resp_sel", bus1.Resp_Sel, hs);
            if (bus1.Resp_Ready) hs++;
            @(negedge clk);
            cyc++;
        end
        bus1.Resp_Valid = 1'b0;
        chk("n1_handshakes", hs, 32);
        lat = 1;
        while (!bus1.Collect_Done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("n1_done_latency", lat, 33);
        e = sb.pop_front();
        chk("n1_data_out", bus1.data_out, e.data);
        chk("n1_unstable", bus1.Unstable_Count, e.unst);
        chk("n1_valid", bus1.Data_Valid, 1);
    endtask

    initial begin
        bus5.Collect_Go = 1'b0;
        bus5.Resp_Valid = 1'b0;
        bus5.Resp_Data  = 8'h00;
        bus1.Collect_Go = 1'b0;
        bus1.Resp_Valid = 1'b0;
        bus1.Resp_Data  = 8'h00;
        Reset = 1'b1;
        #1;
        chk("reset_ready", bus5.Resp_Ready, 0);
        chk("reset_sel", bus5.Resp_Sel, 0);
        chk("reset_done", bus5.Collect_Done, 0);
        chk("reset_valid", bus5.Data_Valid, 0);
        chk("reset_data", bus5.data_out, 0);
        chk("reset_unst", bus5.Unstable_Count, 0);
        @(negedge clk) Reset = 1'b0;

        fill(8'hA5);
        collect5(1'b0, 1'b0, -1);

        fill(8'h3C);
        for (int p = 0; p < 5; p++) pat_mem[p][0] = (p % 2 == 0) ? 8'hFF : 8'h00;
        collect5(1'b0, 1'b0, -1);

        fill(8'hA5);
        collect5(1'b1, 1'b0, -1);

        collect5(1'b0, 1'b0, 70);
        collect5(1'b0, 1'b0, -1);

        collect5(1'b0, 1'b1, -1);
        // Go from IDLE with a valid result: the clear checks run at the start of the next call.
        collect5(1'b0, 1'b0, -1);

        collect1();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
